// File: rtl/global_defs.sv
// Shared types for the request path: parser output record, time and age counters.
package global_defs;

  localparam int QUEUE_SIZE = 8;

  typedef logic [31:0] int_t;
  typedef logic [7:0]  age_counter_t;

  typedef struct packed {
    logic        op_ready_s;
    int_t        time_cpu;
    logic [31:0] addr;
    logic        is_write;
  } parser_out_struct_t;

endpackage

// File: rtl/req_queue_param.sv
// Aging request queue: entries wait AGE_THRESH cycles at the head before issue,
// and queue time jumps forward to the first request's timestamp when idle.
module req_queue_param
  import global_defs::*;
#(
  parameter int DEPTH      = QUEUE_SIZE,
  parameter int AGE_THRESH = 100,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  parser_out_struct_t           in,
  output logic                         in_ready,
  input  logic                         flush,
  output parser_out_struct_t           out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output int_t                         curr_time
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_TH  = AGE_W'(AGE_THRESH);

  parser_out_struct_t r_mem [DEPTH];
  logic [AGE_W-1:0]   r_age [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  parser_out_struct_t r_out;
  logic               r_out_valid;
  int_t               r_time;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_pop;
  logic [DEPTH-1:0]   w_valid;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full && !flush && (w_empty || in.time_cpu <= r_time);
  assign w_accept = in_ready && in.op_ready_s;
  assign w_pop    = !flush && !w_empty && (r_age[r_head] >= AGE_TH) &&
                    (!r_out_valid || out_ready);

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PTR_W'(i) - r_head}) < r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_tail] <= in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_time      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else if (flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_time      <= r_time + 32'd1;
      for (int i = 0; i < DEPTH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      // An idle queue skips ahead to the first request's timestamp.
      r_time <= (w_accept && w_empty) ? in.time_cpu : r_time + 32'd1;

      for (int i = 0; i < DEPTH; i++) begin
        if (w_accept && (PTR_W'(i) == r_tail)) begin
          r_age[i] <= '0;
        end else if (w_valid[i] && (r_age[i] != AGE_MAX)) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end

      if (w_accept) begin
        r_tail <= r_tail + PTR_W'(1);
      end

      if (w_pop) begin
        r_head      <= r_head + PTR_W'(1);
        r_out       <= r_mem[r_head];
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign curr_time = r_time;

endmodule

// File: tb/tb_req_queue_param.sv
// Directed plus randomized bench for req_queue_param against a queue-based
// reference model that ages entries and tracks queue time from the rules.
module tb_req_queue_param;
  import global_defs::*;

  localparam int DEPTH      = 4;
  localparam int AGE_THRESH = 10;
  localparam int AGE_W      = 8;
  localparam int AGE_MAX    = 255;

  logic               clk = 1'b0;
  logic               rst;
  parser_out_struct_t inReq;
  logic               inReady;
  logic               flush;
  parser_out_struct_t outReq;
  logic               outValid;
  logic               outReady;
  logic [2:0]         count;
  logic               full;
  logic               empty;
  int_t               currTime;

  req_queue_param #(
    .DEPTH(DEPTH),
    .AGE_THRESH(AGE_THRESH),
    .AGE_W(AGE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(inReq),
    .in_ready(inReady),
    .flush(flush),
    .out(outReq),
    .out_valid(outValid),
    .out_ready(outReady),
    .count(count),
    .full(full),
    .empty(empty),
    .curr_time(currTime)
  );

  always #5 clk = ~clk;

  typedef struct {
    parser_out_struct_t req;
    int                 age;
  } modelEntry_t;

  modelEntry_t        mQ[$];
  parser_out_struct_t mOut;
  logic               mOutValid;
  int_t               mTime;
  logic               lastAccept;
  int                 nChecks = 0;
  int                 nErrors = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mOut      = '0;
    mOutValid = 1'b0;
    mTime     = '0;
  endtask

  function automatic logic modelReady();
    return (mQ.size() < DEPTH) && !flush && (mQ.size() == 0 || inReq.time_cpu <= mTime);
  endfunction

  task automatic checkOutput();
    check("in_ready",  inReady,  modelReady());
    check("count",     count,    mQ.size());
    check("full",      full,     mQ.size() == DEPTH);
    check("empty",     empty,    mQ.size() == 0);
    check("out_valid", outValid, mOutValid);
    check("out",       outReq,   mOut);
    check("curr_time", currTime, mTime);
  endtask

  // Drives one cycle of inputs, checks outputs, then advances the model by one edge.
  task automatic applyStimulus(input logic v, input int_t tcpu, input logic [31:0] addr,
                               input logic fl, input logic ordy);
    logic        accept;
    logic        pop;
    int          size;
    modelEntry_t head;
    inReq.op_ready_s = v;
    inReq.time_cpu   = tcpu;
    inReq.addr       = addr;
    inReq.is_write   = addr[0];
    flush            = fl;
    outReady         = ordy;
    #1;
    checkOutput();
    size   = mQ.size();
    accept = modelReady() && v;
    pop    = !fl && size > 0 && mQ[0].age >= AGE_THRESH && (!mOutValid || ordy);
    @(posedge clk);
    if (fl) begin
      mQ.delete();
      mOutValid = 1'b0;
      mTime     = mTime + 1;
    end else begin
      mTime = (accept && size == 0) ? tcpu : mTime + 1;
      if (pop) begin
        head      = mQ.pop_front();
        mOut      = head.req;
        mOutValid = 1'b1;
      end else if (ordy) begin
        mOutValid = 1'b0;
      end
      foreach (mQ[i]) begin
        if (mQ[i].age < AGE_MAX) mQ[i].age++;
      end
      if (accept) mQ.push_back('{req: inReq, age: 0});
    end
    lastAccept = accept;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   lat;
    int   rejects;
    logic gotIt;
    int_t tHold;

    rst      = 1'b1;
    inReq    = '0;
    flush    = 1'b0;
    outReady = 1'b0;
    modelReset();
    @(negedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Single request into an empty queue: time skip and fixed issue latency.
    applyStimulus(1'b1, 32'd50, 32'hA0, 1'b0, 1'b1);
    check("t032_time", currTime, 32'd50);
    lat = 0;
    while (!outValid && lat < 30) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      lat++;
    end
    check("t032_latency", lat, AGE_THRESH + 1);
    check("t032_addr", outReq.addr, 32'hA0);
    check("t032_count", count, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    // Fill to full with out stalled, then release and see the fifth get in.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, mTime, 32'h100 + k, 1'b0, 1'b0);
    check("t033_full", full, 1'b1);
    check("t033_count", count, DEPTH);
    tHold = mTime;
    gotIt = 1'b0;
    for (int i = 0; i < 80 && !gotIt; i++) begin
      applyStimulus(1'b1, tHold, 32'h104, 1'b0, 1'b1);
      if (lastAccept) gotIt = 1'b1;
    end
    check("t033_fifth_accepted", gotIt, 1'b1);

    // Future-stamped request waits until queue time catches up.
    tHold   = mTime + 5;
    rejects = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, tHold, 32'h200, 1'b0, 1'b1);
      if (lastAccept) break;
      rejects++;
    end
    check("t034_rejects", rejects, 5);
    repeat (30) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    // Continuous stream wraps the pointers with simultaneous accept and pop.
    for (int k = 0; k < 40; k++) applyStimulus(1'b1, mTime, 32'h300 + k, 1'b0, 1'b1);
    repeat (30) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    // Flush while three entries wait and the output slot is occupied.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, mTime, 32'h400 + k, 1'b0, 1'b0);
    lat = 0;
    while (!outValid && lat < 30) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      lat++;
    end
    check("t036_pre_count", count, 3);
    check("t036_pre_valid", outValid, 1'b1);
    applyStimulus(1'b1, mTime, 32'h4FF, 1'b1, 1'b0);
    check("t036_count", count, 0);
    check("t036_valid", outValid, 1'b0);
    repeat (20) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    repeat (400) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    mTime + 32'($urandom_range(0, 6)) - 32'd3,
                    $urandom,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset in the middle of traffic with a pending output.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, mTime, 32'h500 + k, 1'b0, 1'b0);
    repeat (12) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    check("t037_pre_valid", outValid, 1'b1);
    rst = 1'b1;
    #1;
    check("t037_count", count, 0);
    check("t037_valid", outValid, 1'b0);
    check("t037_out", outReq, '0);
    check("t037_time", currTime, 32'd0);
    check("t037_empty", empty, 1'b1);
    check("t037_full", full, 1'b0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd7, 32'h600, 1'b0, 1'b1);
    repeat (15) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/req_queue_param.md
REQ_QUEUE_PARAM -- requirements
Module: req_queue_param

Interface
REQ-001 SHALL have parameter DEPTH, default QUEUE_SIZE, entry count (>=2, power of two).
REQ-002 SHALL have parameter AGE_THRESH, default 100, age at which the head entry becomes issuable.
REQ-003 SHALL have parameter AGE_W, default 8, age counter width (2^AGE_W-1 >= AGE_THRESH).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in  input  parser_out_struct_t  request from parser; in.op_ready_s is the valid.
REQ-007 SHALL have port in_ready  output  1  request accepted at this edge when high with in.op_ready_s.
REQ-008 SHALL have port flush  input  1  synchronous clear of all entries and the output slot.
REQ-009 SHALL have port out  output  parser_out_struct_t  issued request, registered.
REQ-010 SHALL have port out_valid  output  1  out holds a valid request.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out this cycle.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.
REQ-013 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.
REQ-014 SHALL have port curr_time  output  int_t  queue time.

Function
REQ-015 SHALL store entries in a circular buffer with head/tail pointers and a per-entry age counter.
REQ-016 SHALL drive in_ready combinationally = !full && !flush && (empty || in.time_cpu <= curr_time); no push-through-pop when full.
REQ-017 SHALL, on accept, write in at tail with age 0 and increment count; accept order = issue order.
REQ-018 SHALL increment curr_time by 1 each cycle, except when an accept into an empty queue occurs, which loads curr_time <= in.time_cpu (time skip).
REQ-019 SHALL increment every valid entry's age each cycle, saturating at 2^AGE_W-1.
REQ-020 SHALL pop the head when head age >= AGE_THRESH and (!out_valid || out_ready), loading out and setting out_valid at the same edge.
REQ-021 SHALL clear out_valid on out_ready with no new pop; out SHALL stay stable while out_valid && !out_ready.
REQ-022 SHALL give latency: entry accepted at edge N (no stall) appears with out_valid at edge N+AGE_THRESH+1.
REQ-023 SHALL handle simultaneous accept and pop in one edge: count unchanged, both pointers advance.
REQ-024 SHALL wrap pointers modulo DEPTH without loss or duplication.
REQ-025 SHALL, on flush, empty the queue, clear out_valid and ages at that edge, ignore in that cycle, and keep curr_time counting.
REQ-026 SHALL keep ages counting (saturating) on a head blocked by out stall; issue proceeds on next allowed cycle.

Reset
REQ-027 SHALL on rst: count=0, pointers=0, ages=0, out_valid=0, out='0, curr_time=0; empty=1, full=0, in_ready=1 when in.op_ready_s=0 or in.time_cpu=0.
REQ-028 SHALL drop all content on rst asserted mid-operation, with no output after deassertion until new accepts age.

Structure
REQ-029 SHALL take parser_out_struct_t, int_t, age_counter_t, QUEUE_SIZE from package global_defs; no new package types.
REQ-030 SHALL be synthesizable: fixed arrays, no dynamic queues or blocking updates in sequential blocks.
REQ-031 SHALL need no sub-module; storage, aging and issue logic are inline.

Verification (DEPTH=4, AGE_THRESH=10)
REQ-032 Reset, then one request time_cpu=50 into empty -> accepted, curr_time=50 next cycle, out_valid at accept+11 cycles, count back to 0.
REQ-033 Five back-to-back requests, time_cpu<=curr_time, out_ready=0 -> four accepted, full=1, in_ready=0 on fifth; release out_ready -> four issued in order, fifth then accepted.
REQ-034 Request time_cpu=curr_time+5 into non-empty queue -> in_ready=0 for 5 cycles, then accepted.
REQ-035 Accept and pop in same edge after 6 wrapped entries -> count constant, addresses issued in order, none lost or duplicated.
REQ-036 Flush with 3 entries and out_valid=1 -> next cycle count=0, out_valid=0, no later issue of flushed entries.
REQ-037 rst asserted mid-stream for 1 cycle -> all outputs at reset values immediately (asynchronous), queue empty after.
